// File: rtl/shift_register_with_valid_ready.sv
// rtl/shift_register_with_valid_ready.sv - elastic valid/ready pipeline of depth stages
// Bubbles collapse under backpressure; synchronous flush and registered occupancy count.
module shift_register_with_valid_ready #(
   parameter int width = 8,
   parameter int depth = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [width-1:0]             in_data,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [width-1:0]             out_data,
   output logic [$clog2(depth+1)-1:0]   count
);

   localparam int cw = $clog2(depth+1);

   logic [depth-1:0] v;
   logic [width-1:0] d [depth];
   logic [depth-1:0] adv;
   logic [depth-1:0] v_nxt;
   logic [depth-1:0] load;
   logic [cw-1:0]    count_nxt;

   // A stage may advance when any stage at or downstream of it is empty, or the sink drains.
   always_comb begin
      logic chain;
      adv       = '0;
      v_nxt     = '0;
      load      = '0;
      count_nxt = '0;
      chain     = out_rdy;
      for (int k = depth - 1; k >= 0; k--) begin
         chain  = chain | ~v[k];
         adv[k] = chain;
      end
      v_nxt[0] = flush ? 1'b0 : (adv[0] ? in_vld : v[0]);
      load[0]  = ~flush & adv[0] & in_vld;
      for (int k = 1; k < depth; k++) begin
         v_nxt[k] = flush ? 1'b0 : (adv[k] ? v[k-1] : v[k]);
         load[k]  = ~flush & adv[k] & v[k-1];
      end
      for (int k = 0; k < depth; k++) begin
         count_nxt = count_nxt + cw'(v_nxt[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v     <= '0;
         count <= '0;
         for (int k = 0; k < depth; k++) begin
            d[k] <= '0;
         end
      end else begin
         v     <= v_nxt;
         count <= count_nxt;
         if (load[0]) begin
            d[0] <= in_data;
         end
         for (int k = 1; k < depth; k++) begin
            if (load[k]) begin
               d[k] <= d[k-1];
            end
         end
      end
   end

   assign in_rdy   = adv[0] & ~flush;
   assign out_vld  = v[depth-1];
   assign out_data = d[depth-1];

endmodule
